// File: rtl/alphacore_pkg.sv
// Shared constants and state type for the core program-load sequencer.
package alphacore_pkg;
  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;
  localparam int          IMEM_DEPTH = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_RUN,
    S_DONE
  } seq_state_t;
endpackage

// File: rtl/core_sequencer_if.sv
// Instruction-word load stream between the host and the sequencer.
// The host is the master; the sequencer accepts words only in IDLE while the bank has room.
interface core_sequencer_if;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic        load_last;

  modport master (output load_valid, output load_data, output load_last, input load_ready);
  modport slave  (input load_valid, input load_data, input load_last, output load_ready);
endinterface

// File: rtl/core_sequencer_imem_bank.sv
// DEPTH x 32 instruction bank: one write per cycle, tail NOP-fill when the last word lands.
// Writes land on the accepting edge; the caller gates writes using full_o.
module imem_bank
  import alphacore_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en_i,
  input  logic        wr_last_i,
  input  logic [31:0] wr_data_i,
  input  logic        ptr_clr_i,
  output logic        full_o,
  output logic [31:0] idata0_o,  idata1_o,  idata2_o,  idata3_o,
  output logic [31:0] idata4_o,  idata5_o,  idata6_o,  idata7_o,
  output logic [31:0] idata8_o,  idata9_o,  idata10_o, idata11_o,
  output logic [31:0] idata12_o, idata13_o, idata14_o, idata15_o,
  output logic [31:0] idata16_o, idata17_o, idata18_o, idata19_o,
  output logic [31:0] idata20_o, idata21_o, idata22_o, idata23_o,
  output logic [31:0] idata24_o, idata25_o, idata26_o, idata27_o,
  output logic [31:0] idata28_o, idata29_o, idata30_o, idata31_o
);
  localparam int PTR_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][31:0] bank_q, bank_d;
  logic [PTR_W-1:0]       wptr_q, wptr_d;

  always_comb begin
    bank_d = bank_q;
    wptr_d = wptr_q;
    if (wr_en_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == int'(wptr_q))                  bank_d[i] = wr_data_i;
        else if (wr_last_i && i > int'(wptr_q)) bank_d[i] = NOP_INSN;
      end
      wptr_d = wr_last_i ? '0 : wptr_q + 1'b1;
    end
    // A new run always restarts loading from word 0.
    if (ptr_clr_i) wptr_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q <= {DEPTH{NOP_INSN}};
      wptr_q <= '0;
    end else begin
      bank_q <= bank_d;
      wptr_q <= wptr_d;
    end
  end

  assign full_o = (wptr_q == PTR_W'(DEPTH));

  assign {idata31_o, idata30_o, idata29_o, idata28_o, idata27_o, idata26_o, idata25_o, idata24_o,
          idata23_o, idata22_o, idata21_o, idata20_o, idata19_o, idata18_o, idata17_o, idata16_o,
          idata15_o, idata14_o, idata13_o, idata12_o, idata11_o, idata10_o, idata9_o,  idata8_o,
          idata7_o,  idata6_o,  idata5_o,  idata4_o,  idata3_o,  idata2_o,  idata1_o,  idata0_o} = bank_q;
endmodule

// File: rtl/core_sequencer.sv
// Program-load and run controller: fills the instruction bank, then holds the core in reset,
// runs it for a programmed cycle count and freezes it. Outputs registered; load_ready from state/wptr.
module core_sequencer
  import alphacore_pkg::*;
#(
  parameter int DEPTH        = IMEM_DEPTH,
  parameter int RESET_CYCLES = 5,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  core_sequencer_if.slave  load,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] run_cycles_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             core_reset_o,
  output logic             core_clk_en_o,
  output logic [31:0]      idata0_o,  idata1_o,  idata2_o,  idata3_o,
  output logic [31:0]      idata4_o,  idata5_o,  idata6_o,  idata7_o,
  output logic [31:0]      idata8_o,  idata9_o,  idata10_o, idata11_o,
  output logic [31:0]      idata12_o, idata13_o, idata14_o, idata15_o,
  output logic [31:0]      idata16_o, idata17_o, idata18_o, idata19_o,
  output logic [31:0]      idata20_o, idata21_o, idata22_o, idata23_o,
  output logic [31:0]      idata24_o, idata25_o, idata26_o, idata27_o,
  output logic [31:0]      idata28_o, idata29_o, idata30_o, idata31_o
);
  localparam int HOLD_W = $clog2(RESET_CYCLES + 1);

  logic [1:0]        rst_sync_q;
  logic              rst_n;
  seq_state_t        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  run_q, run_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              core_reset_q, core_reset_d, core_clk_en_q, core_clk_en_d;
  logic              full, accept, take_start;

  // Assert immediately, release two edges later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign load.load_ready = (state_q == S_IDLE) && !full;
  assign accept          = load.load_valid && load.load_ready;
  assign take_start      = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    run_d   = run_q;
    case (state_q)
      S_IDLE: ;
      S_HOLD: begin
        if (abort_i)            state_d = S_DONE;
        else if (hold_q == '0)  state_d = S_RUN;
        else                    hold_d  = hold_q - 1'b1;
      end
      S_RUN: begin
        // A zero count never reaches 1, so the run only ends on abort.
        if (abort_i || run_q == CNT_W'(1)) state_d = S_DONE;
        else if (run_q != '0)              run_d   = run_q - 1'b1;
      end
      S_DONE: if (load.load_valid) state_d = S_IDLE;
    endcase
    if (take_start) begin
      state_d = S_HOLD;
      hold_d  = HOLD_W'(RESET_CYCLES - 1);
      run_d   = run_cycles_i;
    end
    busy_d        = (state_d == S_HOLD) || (state_d == S_RUN);
    done_d        = (state_d == S_DONE);
    core_clk_en_d = busy_d;
    core_reset_d  = (state_d == S_HOLD) || ((state_d == S_IDLE) && core_reset_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      hold_q        <= '0;
      run_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      core_reset_q  <= 1'b1;
      core_clk_en_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      run_q         <= run_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      core_reset_q  <= core_reset_d;
      core_clk_en_q <= core_clk_en_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign core_reset_o  = core_reset_q;
  assign core_clk_en_o = core_clk_en_q;

  imem_bank #(.DEPTH(DEPTH)) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (accept),
    .wr_last_i (load.load_last),
    .wr_data_i (load.load_data),
    .ptr_clr_i (take_start),
    .full_o    (full),
    .idata0_o  (idata0_o),  .idata1_o  (idata1_o),  .idata2_o  (idata2_o),  .idata3_o  (idata3_o),
    .idata4_o  (idata4_o),  .idata5_o  (idata5_o),  .idata6_o  (idata6_o),  .idata7_o  (idata7_o),
    .idata8_o  (idata8_o),  .idata9_o  (idata9_o),  .idata10_o (idata10_o), .idata11_o (idata11_o),
    .idata12_o (idata12_o), .idata13_o (idata13_o), .idata14_o (idata14_o), .idata15_o (idata15_o),
    .idata16_o (idata16_o), .idata17_o (idata17_o), .idata18_o (idata18_o), .idata19_o (idata19_o),
    .idata20_o (idata20_o), .idata21_o (idata21_o), .idata22_o (idata22_o), .idata23_o (idata23_o),
    .idata24_o (idata24_o), .idata25_o (idata25_o), .idata26_o (idata26_o), .idata27_o (idata27_o),
    .idata28_o (idata28_o), .idata29_o (idata29_o), .idata30_o (idata30_o), .idata31_o (idata31_o)
  );
endmodule

// File: tb/tb_core_sequencer.sv
// Directed and randomised stimulus for core_sequencer, checked every cycle against a
// model that tracks run phases by elapsed cycles since start.
module tb_core_sequencer;
  localparam int          R      = 5;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam int          M_IDLE = 0, M_HOLD = 1, M_RUN = 2, M_DONE = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i, abort_i;
  logic [15:0] run_cycles_i;
  logic        busy_o, done_o, core_reset_o, core_clk_en_o;
  logic [31:0] idata [32];

  core_sequencer_if ifc ();

  core_sequencer #(.DEPTH(32), .RESET_CYCLES(R), .CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .load         (ifc),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .run_cycles_i (run_cycles_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .core_reset_o (core_reset_o),
    .core_clk_en_o(core_clk_en_o),
    .idata0_o (idata[0]),  .idata1_o (idata[1]),  .idata2_o (idata[2]),  .idata3_o (idata[3]),
    .idata4_o (idata[4]),  .idata5_o (idata[5]),  .idata6_o (idata[6]),  .idata7_o (idata[7]),
    .idata8_o (idata[8]),  .idata9_o (idata[9]),  .idata10_o(idata[10]), .idata11_o(idata[11]),
    .idata12_o(idata[12]), .idata13_o(idata[13]), .idata14_o(idata[14]), .idata15_o(idata[15]),
    .idata16_o(idata[16]), .idata17_o(idata[17]), .idata18_o(idata[18]), .idata19_o(idata[19]),
    .idata20_o(idata[20]), .idata21_o(idata[21]), .idata22_o(idata[22]), .idata23_o(idata[23]),
    .idata24_o(idata[24]), .idata25_o(idata[25]), .idata26_o(idata[26]), .idata27_o(idata[27]),
    .idata28_o(idata[28]), .idata29_o(idata[29]), .idata30_o(idata[30]), .idata31_o(idata[31])
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  string       phase = "init";
  logic [31:0] m_bank [32];
  int          m_wptr, m_state, m_t, m_n;
  bit          m_rst;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL [%s] %s: got %h, expected %h", phase, tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_bank[i] = NOP;
    m_wptr  = 0;
    m_state = M_IDLE;
    m_t     = 0;
    m_n     = 0;
    m_rst   = 1'b1;
  endtask

  task automatic begin_run(input int rc);
    m_state = M_HOLD;
    m_t     = 0;
    m_n     = rc;
    m_wptr  = 0;
  endtask

  // One clock edge of the reference behaviour, given the inputs sampled on it.
  task automatic model_edge(input bit v, input logic [31:0] d, input bit l,
                            input bit st, input bit ab, input int rc);
    bit rdy;
    rdy = (m_state == M_IDLE) && (m_wptr < 32);
    if (v && rdy) begin
      m_bank[m_wptr] = d;
      if (l) begin
        for (int i = m_wptr + 1; i < 32; i++) m_bank[i] = NOP;
        m_wptr = 0;
      end else begin
        m_wptr++;
      end
    end
    case (m_state)
      M_IDLE: if (st) begin_run(rc);
      M_HOLD, M_RUN: begin
        if (ab) m_state = M_DONE;
        else begin
          m_t++;
          if (m_t < R)                         m_state = M_HOLD;
          else if (m_n == 0 || m_t < R + m_n)  m_state = M_RUN;
          else                                 m_state = M_DONE;
        end
      end
      default: begin
        if (st)     begin_run(rc);
        else if (v) m_state = M_IDLE;
      end
    endcase
    if (m_state == M_HOLD)      m_rst = 1'b1;
    else if (m_state != M_IDLE) m_rst = 1'b0;
  endtask

  task automatic check_all();
    chk("load_ready",  32'(ifc.load_ready),  32'((m_state == M_IDLE) && (m_wptr < 32)));
    chk("busy",        32'(busy_o),          32'((m_state == M_HOLD) || (m_state == M_RUN)));
    chk("done",        32'(done_o),          32'(m_state == M_DONE));
    chk("core_reset",  32'(core_reset_o),    32'(m_rst));
    chk("core_clk_en", 32'(core_clk_en_o),   32'((m_state == M_HOLD) || (m_state == M_RUN)));
    for (int i = 0; i < 32; i++) chk($sformatf("idata%0d", i), idata[i], m_bank[i]);
  endtask

  // Drive inputs after a falling edge, let the DUT and model see the rising edge, check at the next falling edge.
  task automatic step(input bit v, input logic [31:0] d, input bit l,
                      input bit st, input bit ab, input logic [15:0] rc);
    ifc.load_valid = v;
    ifc.load_data  = d;
    ifc.load_last  = l;
    start_i        = st;
    abort_i        = ab;
    run_cycles_i   = rc;
    @(posedge clk);
    model_edge(v, d, l, st, ab, int'(rc));
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic apply_reset();
    ifc.load_valid = 1'b0;
    start_i        = 1'b0;
    abort_i        = 1'b0;
    #2 reset = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_all();
  endtask

  initial begin
    bit          v, l, st, ab;
    logic [31:0] d;

    ifc.load_valid = 1'b0;
    ifc.load_data  = '0;
    ifc.load_last  = 1'b0;
    start_i        = 1'b0;
    abort_i        = 1'b0;
    run_cycles_i   = '0;
    reset          = 1'b1;
    model_reset();
    #3 reset = 1'b0;
    @(negedge clk);
    phase = "in_reset";
    check_all();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    phase = "post_reset";
    check_all();

    phase = "load3_last";
    step(1'b1, 32'h12345337, 1'b0, 1'b0, 1'b0, 16'd0);
    step(1'b1, 32'h67830313, 1'b0, 1'b0, 1'b0, 16'd0);
    step(1'b1, 32'h0FF50513, 1'b1, 1'b0, 1'b0, 16'd0);

    phase = "load32_full";
    for (int i = 0; i < 32; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 16'd0);
    step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 16'd0);
    step(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 16'd0);

    phase = "run10";
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 16'd10);
    idle(20);

    phase = "rerun_unbounded_abort";
    step(1'b1, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 16'd0);
    idle(20);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 16'd0);
    idle(3);

    phase = "done_to_idle_reload";
    step(1'b1, 32'h00100093, 1'b0, 1'b0, 1'b0, 16'd0);
    step(1'b1, 32'h00100093, 1'b0, 1'b0, 1'b0, 16'd0);
    step(1'b1, 32'h00200113, 1'b1, 1'b0, 1'b0, 16'd0);

    phase = "reset_in_run";
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 16'd30);
    idle(9);
    apply_reset();

    phase = "random";
    v = 1'b0;
    l = 1'b0;
    d = '0;
    for (int c = 0; c < 1500; c++) begin
      // Payload stays put while a word is offered but not taken.
      if (!(v && !ifc.load_ready)) begin
        v = 1'($urandom_range(0, 1));
        d = $urandom;
        l = ($urandom_range(0, 7) == 0);
      end
      st = ($urandom_range(0, 15) == 0);
      ab = ($urandom_range(0, 23) == 0);
      step(v, d, l, st, ab, 16'($urandom_range(0, 12)));
      if ($urandom_range(0, 299) == 0) begin
        apply_reset();
        v = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
